// File: rtl/ides_gearbox.sv
// Parametrised soft deserializer with per-lane bitslip and training FSM.
// Optional IDES_TRAIN_TIMEOUT_EN adds fail_o and a slip-count timeout per lane.
module ides_gearbox #(
  parameter int                RATIO         = 4,
  parameter int                CHANNELS      = 1,
  parameter logic [RATIO-1:0]  TRAIN_PATTERN = 4'b0011,
  parameter int                LOCK_COUNT    = 4
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic [CHANNELS-1:0]          data_i,
  input  logic                         calib_i,
  input  logic                         train_i,
  output logic [CHANNELS*RATIO-1:0]    q_o,
  output logic [CHANNELS-1:0]          q_valid_o,
  output logic [CHANNELS-1:0]          locked_o
`ifdef IDES_TRAIN_TIMEOUT_EN
  ,
  output logic [CHANNELS-1:0]          fail_o
`endif
);

  localparam int PW = $clog2(RATIO);
`ifdef IDES_TRAIN_TIMEOUT_EN
  localparam int SW = $clog2(2*RATIO+1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_SETTLE, S_LOCKED, S_FAIL} state_t;

  logic calib_q;
  logic train_q;
  logic calib_rise;
  logic train_rise;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      calib_q <= 1'b0;
      train_q <= 1'b0;
    end else begin
      calib_q <= calib_i;
      train_q <= train_i;
    end
  end

  assign calib_rise = calib_i & ~calib_q;
  assign train_rise = train_i & ~train_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic [RATIO-1:0] shreg;
    logic [RATIO-1:0] word;
    logic [RATIO-1:0] q_word;
    logic             q_valid;
    logic [PW-1:0]    phase;
    logic             hold;
    logic             word_done;
    logic             slip;
    logic             fsm_slip;
    logic             locked;
    state_t           state;
    state_t           state_nx;
    logic [7:0]       match_cnt;
    logic [7:0]       match_nx;
    logic             settle_cnt;
    logic             settle_nx;
`ifdef IDES_TRAIN_TIMEOUT_EN
    logic [SW-1:0]    slip_cnt;
    logic [SW-1:0]    slip_nx;
    logic             fail;
`endif

    // Newest bit enters at the MSB so the earliest bit of a word lands in bit 0.
    assign word      = {data_i[g], shreg[RATIO-1:1]};
    assign word_done = (phase == PW'(RATIO-1)) && !hold;
    assign slip      = fsm_slip | (calib_rise & ((state == S_IDLE) || (state == S_LOCKED)));

    // A slip freezes the phase counter on the following cycle only; overlapping requests are dropped.
    always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
        shreg   <= '0;
        phase   <= '0;
        hold    <= 1'b0;
        q_word  <= '0;
        q_valid <= 1'b0;
      end else begin
        shreg   <= word;
        hold    <= slip & ~hold;
        q_valid <= word_done;
        if (!hold)
          phase <= word_done ? '0 : phase + 1'b1;
        if (word_done)
          q_word <= word;
      end
    end

    always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
        state      <= S_IDLE;
        match_cnt  <= '0;
        settle_cnt <= 1'b0;
`ifdef IDES_TRAIN_TIMEOUT_EN
        slip_cnt   <= '0;
`endif
      end else begin
        state      <= state_nx;
        match_cnt  <= match_nx;
        settle_cnt <= settle_nx;
`ifdef IDES_TRAIN_TIMEOUT_EN
        slip_cnt   <= slip_nx;
`endif
      end
    end

    always_comb begin
      state_nx  = state;
      match_nx  = match_cnt;
      settle_nx = settle_cnt;
`ifdef IDES_TRAIN_TIMEOUT_EN
      slip_nx   = slip_cnt;
`endif
      case (state)
        S_IDLE: begin
          if (train_i) begin
            state_nx = S_SEARCH;
            match_nx = '0;
`ifdef IDES_TRAIN_TIMEOUT_EN
            slip_nx  = '0;
`endif
          end
        end
        S_SEARCH: begin
          if (!train_i) begin
            state_nx = S_IDLE;
          end else if (word_done) begin
            if (word == TRAIN_PATTERN) begin
              match_nx = match_cnt + 8'd1;
              if (match_cnt == 8'(LOCK_COUNT-1))
                state_nx = S_LOCKED;
            end else begin
              match_nx  = '0;
              settle_nx = 1'b0;
              state_nx  = S_SETTLE;
`ifdef IDES_TRAIN_TIMEOUT_EN
              slip_nx   = slip_cnt + 1'b1;
              if (slip_cnt == SW'(2*RATIO-1))
                state_nx = S_FAIL;
`endif
            end
          end
        end
        S_SETTLE: begin
          if (!train_i) begin
            state_nx = S_IDLE;
          end else if (word_done) begin
            settle_nx = ~settle_cnt;
            if (settle_cnt)
              state_nx = S_SEARCH;
          end
        end
        S_LOCKED: begin
          if (train_rise) begin
            state_nx = S_SEARCH;
            match_nx = '0;
`ifdef IDES_TRAIN_TIMEOUT_EN
            slip_nx  = '0;
`endif
          end
        end
`ifdef IDES_TRAIN_TIMEOUT_EN
        S_FAIL: begin
          if (!train_i)
            state_nx = S_IDLE;
        end
`endif
        default: state_nx = S_IDLE;
      endcase
    end

    always_comb begin
      locked   = (state == S_LOCKED);
      fsm_slip = (state == S_SEARCH) && train_i && word_done && (word != TRAIN_PATTERN);
`ifdef IDES_TRAIN_TIMEOUT_EN
      fail     = (state == S_FAIL);
`endif
    end

    assign q_o[g*RATIO +: RATIO] = q_word;
    assign q_valid_o[g]          = q_valid;
    assign locked_o[g]           = locked;
`ifdef IDES_TRAIN_TIMEOUT_EN
    assign fail_o[g]             = fail;
`endif
  end

endmodule

// File: tb/tb_ides_gearbox.sv
// Directed testbench for ides_gearbox (RATIO=4, two lanes); the timeout
// scenario is built only when IDES_TRAIN_TIMEOUT_EN is defined.
module tb_ides_gearbox;

  localparam int         RATIO    = 4;
  localparam int         CHANNELS = 2;
  localparam logic [3:0] PATTERN  = 4'b0011;

  logic                      clk = 1'b0;
  logic                      rst_i;
  logic [CHANNELS-1:0]       data_i;
  logic                      calib_i;
  logic                      train_i;
  logic [CHANNELS*RATIO-1:0] q_o;
  logic [CHANNELS-1:0]       q_valid_o;
  logic [CHANNELS-1:0]       locked_o;
`ifdef IDES_TRAIN_TIMEOUT_EN
  logic [CHANNELS-1:0]       fail_o;
`endif

  int checks = 0;
  int errors = 0;

  // Edges since reset release, and the per-lane stream generator settings.
  int         cyc  = 0;
  int         off0 = 0;
  int         off1 = 0;
  logic [3:0] seq  = 4'b0000;

  ides_gearbox #(
    .RATIO(RATIO), .CHANNELS(CHANNELS), .TRAIN_PATTERN(PATTERN), .LOCK_COUNT(4)
  ) dut (
    .clk(clk), .rst_i(rst_i), .data_i(data_i), .calib_i(calib_i), .train_i(train_i),
    .q_o(q_o), .q_valid_o(q_valid_o), .locked_o(locked_o)
`ifdef IDES_TRAIN_TIMEOUT_EN
    , .fail_o(fail_o)
`endif
  );

  always #5 clk = ~clk;

  // Serial bit for edge index c of a 4-bit repeating sequence delayed by off bits.
  function automatic logic sbit(input logic [3:0] s, input int c, input int off);
    int idx;
    idx = (((c - off) % 4) + 4) % 4;
    return s[idx];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    data_i = {sbit(seq, cyc, off1), sbit(seq, cyc, off0)};
    step();
    cyc++;
  endtask

  task automatic do_reset(input logic train);
    rst_i   = 1'b0;
    calib_i = 1'b0;
    train_i = train;
    data_i  = '0;
    repeat (3) step();
    rst_i = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; calib_i = 1'b0; train_i = 1'b0; data_i = '0;
    #2;
    checks++;
    if (q_o !== '0) begin errors++; $display("[TB] FAIL reset_q: got %h expected 0", q_o); end
    step(); step();
    checks++;
    if (q_valid_o !== '0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", q_valid_o); end
    checks++;
    if (locked_o !== '0) begin errors++; $display("[TB] FAIL reset_locked: got %b expected 0", locked_o); end
  endtask

  task automatic test_datapath();
    logic exp_v;
    $display("[TB] datapath 1,0,1,1");
    seq = 4'b1101; off0 = 0; off1 = 0;
    do_reset(1'b0);
    for (int n = 1; n <= 16; n++) begin
      tick();
      exp_v = (n % 4 == 0);
      checks++;
      if (q_valid_o !== {2{exp_v}}) begin
        errors++; $display("[TB] FAIL dp_valid edge %0d: got %b expected %b", n, q_valid_o, {2{exp_v}});
      end
      if (exp_v) begin
        checks++;
        if (q_o !== 8'hDD) begin errors++; $display("[TB] FAIL dp_word edge %0d: got %h expected dd", n, q_o); end
      end
    end
  endtask

  task automatic test_bitslip();
    logic       exp_v;
    logic [3:0] exp_q;
    $display("[TB] bitslip with calib held high");
    seq = 4'b1101; off0 = 0; off1 = 0;
    do_reset(1'b0);
    for (int n = 1; n <= 28; n++) begin
      calib_i = (n >= 9 && n <= 18);
      tick();
      exp_v = (n <= 8) ? (n % 4 == 0) : (n >= 13 && ((n - 13) % 4 == 0));
      exp_q = (n <= 8) ? 4'b1101 : 4'b1110;
      checks++;
      if (q_valid_o !== {2{exp_v}}) begin
        errors++; $display("[TB] FAIL slip_valid edge %0d: got %b expected %b", n, q_valid_o, {2{exp_v}});
      end
      if (exp_v) begin
        checks++;
        if (q_o !== {exp_q, exp_q}) begin
          errors++; $display("[TB] FAIL slip_word edge %0d: got %h expected %h", n, q_o, {exp_q, exp_q});
        end
      end
    end
    calib_i = 1'b0;
  endtask

  task automatic test_training(input int o0, input int o1, input int exp_slips0, input int exp_slips1,
                               input int exp_lock0, input int exp_lock1);
    int last [2];
    int slips [2];
    int lock_at [2];
    $display("[TB] training offsets %0d/%0d", o0, o1);
    seq = PATTERN; off0 = o0; off1 = o1;
    do_reset(1'b1);
    for (int l = 0; l < 2; l++) begin last[l] = 0; slips[l] = 0; lock_at[l] = 0; end
    for (int n = 1; n <= 80; n++) begin
      tick();
      for (int l = 0; l < 2; l++) begin
        if (locked_o[l] && lock_at[l] == 0) lock_at[l] = n;
        if (q_valid_o[l]) begin
          if (last[l] > 0 && n - last[l] == 5) slips[l]++;
          last[l] = n;
          if (locked_o[l]) begin
            checks++;
            if (q_o[l*4 +: 4] !== PATTERN) begin
              errors++; $display("[TB] FAIL train_word lane %0d edge %0d: got %b expected %b", l, n, q_o[l*4 +: 4], PATTERN);
            end
          end
        end
      end
    end
    checks++;
    if (lock_at[0] != exp_lock0) begin errors++; $display("[TB] FAIL lock_edge lane 0: got %0d expected %0d", lock_at[0], exp_lock0); end
    checks++;
    if (lock_at[1] != exp_lock1) begin errors++; $display("[TB] FAIL lock_edge lane 1: got %0d expected %0d", lock_at[1], exp_lock1); end
    checks++;
    if (slips[0] != exp_slips0) begin errors++; $display("[TB] FAIL slips lane 0: got %0d expected %0d", slips[0], exp_slips0); end
    checks++;
    if (slips[1] != exp_slips1) begin errors++; $display("[TB] FAIL slips lane 1: got %0d expected %0d", slips[1], exp_slips1); end
  endtask

  task automatic test_lock_exit();
    $display("[TB] lock exit and retrain");
    train_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (locked_o !== 2'b11) begin errors++; $display("[TB] FAIL lock_hold: got %b expected 11", locked_o); end
    train_i = 1'b1;
    tick();
    checks++;
    if (locked_o !== 2'b00) begin errors++; $display("[TB] FAIL lock_retrain_clear: got %b expected 00", locked_o); end
    repeat (24) tick();
    checks++;
    if (locked_o !== 2'b11) begin errors++; $display("[TB] FAIL relock: got %b expected 11", locked_o); end
  endtask

  task automatic test_reset_mid();
    int n;
    $display("[TB] reset while locked");
    n = 0;
    while (q_valid_o[0] !== 1'b1 && n < 8) begin tick(); n++; end
    checks++;
    if (q_valid_o[0] !== 1'b1) begin errors++; $display("[TB] FAIL mid_find_word: got %b expected 1", q_valid_o[0]); end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if ({q_o, q_valid_o, locked_o} !== '0) begin
      errors++; $display("[TB] FAIL mid_reset_outputs: got %h/%b/%b expected 0", q_o, q_valid_o, locked_o);
    end
    train_i = 1'b0;
    step();
    rst_i = 1'b1;
    cyc   = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k <= 4) begin
        checks++;
        if (q_valid_o[0] !== (k == 4)) begin
          errors++; $display("[TB] FAIL post_reset_valid edge %0d: got %b expected %b", k, q_valid_o[0], (k == 4));
        end
      end
      checks++;
      if (locked_o !== 2'b00) begin errors++; $display("[TB] FAIL post_reset_locked edge %0d: got %b expected 00", k, locked_o); end
    end
  endtask

`ifdef IDES_TRAIN_TIMEOUT_EN
  task automatic test_timeout();
    int fail_at;
    $display("[TB] training timeout on constant 0");
    seq = 4'b0000; off0 = 0; off1 = 0;
    do_reset(1'b1);
    fail_at = 0;
    for (int n = 1; n <= 200 && fail_at == 0; n++) begin
      tick();
      if (fail_o[0]) fail_at = n;
    end
    checks++;
    if (fail_at != 95) begin errors++; $display("[TB] FAIL timeout_edge: got %0d expected 95", fail_at); end
    checks++;
    if (fail_o !== 2'b11 || locked_o !== 2'b00) begin
      errors++; $display("[TB] FAIL timeout_state: got fail %b locked %b expected 11/00", fail_o, locked_o);
    end
    train_i = 1'b0;
    tick();
    checks++;
    if (fail_o !== 2'b00) begin errors++; $display("[TB] FAIL timeout_clear: got %b expected 00", fail_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_datapath();
    test_bitslip();
    test_training(2, 3, 2, 3, 42, 55);
    test_training(0, 3, 0, 3, 16, 55);
    test_lock_exit();
    test_reset_mid();
`ifdef IDES_TRAIN_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
